// File: rtl/gpu_sram_pkg.sv
// rtl/gpu_sram_pkg.sv - shared widths, beat count and FSM state type for the SRAM line path
package gpu_sram_pkg;

  localparam int LINE_W = 1536;
  localparam int PIX_W  = 24;
  localparam int ADDR_W = 24;
  localparam int BEATS  = 64;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_DRAIN,
    DONE
  } state_t;

  function automatic logic [PIX_W-1:0] line_pixel(input logic [LINE_W-1:0] line,
                                                  input int idx);
    return line[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/sram_line_buffer.sv
// rtl/sram_line_buffer.sv - write-line staging store and read-line capture store, 64 pixels each
module sram_line_buffer
  import gpu_sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  input  logic [BEAT_W-1:0] rd_idx,
  output logic [PIX_W-1:0]  rd_pix,
  input  logic              cap_en,
  input  logic [BEAT_W-1:0] cap_idx,
  input  logic [PIX_W-1:0]  cap_pix,
  output logic [LINE_W-1:0] read_line
);

  // Separate stores so that staging a write line never disturbs the last read line.
  logic [BEATS-1:0][PIX_W-1:0] wline_q;
  logic [BEATS-1:0][PIX_W-1:0] wline_d;
  logic [BEATS-1:0][PIX_W-1:0] rline_q;
  logic [BEATS-1:0][PIX_W-1:0] rline_d;

  always_comb begin
    wline_d = wline_q;
    rline_d = rline_q;
    if (load_en) begin
      for (int i = 0; i < BEATS; i++) begin
        wline_d[i] = line_pixel(load_line, i);
      end
    end
    if (cap_en) begin
      rline_d[cap_idx] = cap_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign rd_pix    = wline_q[rd_idx];
  assign read_line = rline_q;

endmodule

// File: rtl/sram_line_ctrl.sv
// rtl/sram_line_ctrl.sv - serialises 1536-bit line requests into 64 pixel SRAM beats
// Optional rd_count/wr_count outputs when SRAM_LINE_CTRL_PERF_CNT_EN is defined.
module sram_line_ctrl
  import gpu_sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [LINE_W-1:0] write_data,
  output logic [LINE_W-1:0] read_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
`ifdef SRAM_LINE_CTRL_PERF_CNT_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
`endif
  input  logic [PIX_W-1:0]  mem_rdata
);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              cap_vld_q, cap_vld_d;
  logic [BEAT_W-1:0] cap_idx_q, cap_idx_d;

  logic              load_en;
  logic [BEAT_W-1:0] next_beat;
  logic [PIX_W-1:0]  buf_pix;

  assign next_beat = beat_q + BEAT_W'(1);

  sram_line_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_line (write_data),
    .rd_idx    (next_beat),
    .rd_pix    (buf_pix),
    .cap_en    (cap_vld_q),
    .cap_idx   (cap_idx_q),
    .cap_pix   (mem_rdata),
    .read_line (read_data)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    load_en     = 1'b0;
    // Read data returns one cycle after the strobe, so the slot index trails by one.
    cap_vld_d   = mem_re_q;
    cap_idx_d   = beat_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (write_enable) begin
          state_d     = WRITE;
          base_d      = address;
          beat_d      = '0;
          busy_d      = 1'b1;
          load_en     = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = address;
          mem_wdata_d = line_pixel(write_data, 0);
        end else if (read_enable) begin
          state_d    = READ;
          base_d     = address;
          beat_d     = '0;
          busy_d     = 1'b1;
          mem_re_d   = 1'b1;
          mem_addr_d = address;
        end
      end
      WRITE: begin
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          beat_d      = next_beat;
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + ADDR_W'(next_beat);
          mem_wdata_d = buf_pix;
        end
      end
      READ: begin
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = READ_DRAIN;
        end else begin
          beat_d     = next_beat;
          mem_re_d   = 1'b1;
          mem_addr_d = base_q + ADDR_W'(next_beat);
        end
      end
      READ_DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

`ifdef SRAM_LINE_CTRL_PERF_CNT_EN
  logic        op_wr_q, op_wr_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    op_wr_d  = op_wr_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == IDLE) begin
      op_wr_d = write_enable;
    end
    if (done_q) begin
      if (op_wr_q) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      op_wr_q  <= op_wr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_line_ctrl.sv
// tb/tb_sram_line_ctrl.sv - directed table-driven bench for sram_line_ctrl with a behavioural SRAM
module tb_sram_line_ctrl;

  logic           clk = 1'b0;
  logic           rst;
  logic           read_enable;
  logic           write_enable;
  logic [23:0]    address;
  logic [1535:0]  write_data;
  logic [1535:0]  read_data;
  logic           busy;
  logic           done;
  logic [23:0]    mem_addr;
  logic [23:0]    mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic [23:0]    mem_rdata = '0;
`ifdef SRAM_LINE_CTRL_PERF_CNT_EN
  logic [31:0]    rd_count;
  logic [31:0]    wr_count;
`endif

  sram_line_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .busy         (busy),
    .done         (done),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
`ifdef SRAM_LINE_CTRL_PERF_CNT_EN
    .rd_count     (rd_count),
    .wr_count     (wr_count),
`endif
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [23:0] sram [int];

  always @(posedge clk) begin
    if (mem_we) sram[int'(mem_addr)] = mem_wdata;
    if (mem_re) mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 24'h0;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // op: 0 write, 1 read, 2 both enables high
  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [23:0] seed;
    int          exp_lat;
    int          exp_we;
    int          exp_re;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
    logic        rd_zero;
    logic [23:0] rd_seed;
  } vec_t;

  vec_t vecs [6];

  function automatic int line_mismatches(input logic [1535:0] line, input logic zero,
                                         input logic [23:0] seed);
    int m = 0;
    for (int p = 0; p < 64; p++) begin
      logic [23:0] e = zero ? 24'h0 : seed + 24'(p);
      if (line[p*24 +: 24] !== e) m++;
    end
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, we_n, re_n, seq_err, both_n, busy_err, mism, done_n, strobe_n;
    logic [23:0] first_a, last_a;

    vecs[0] = '{2'd0, 24'h000100, 24'h0A0000, 65, 64, 0,  24'h000100, 24'h00013F, 1'b1, 24'h000000};
    vecs[1] = '{2'd1, 24'h000100, 24'h000000, 66, 0,  64, 24'h000100, 24'h00013F, 1'b0, 24'h0A0000};
    vecs[2] = '{2'd0, 24'hFFFFF0, 24'h0B0000, 65, 64, 0,  24'hFFFFF0, 24'h00002F, 1'b0, 24'h0A0000};
    vecs[3] = '{2'd1, 24'hFFFFF0, 24'h000000, 66, 0,  64, 24'hFFFFF0, 24'h00002F, 1'b0, 24'h0B0000};
    vecs[4] = '{2'd2, 24'h000200, 24'h0C0000, 65, 64, 0,  24'h000200, 24'h00023F, 1'b0, 24'h0B0000};
    vecs[5] = '{2'd1, 24'h000200, 24'h000000, 66, 0,  64, 24'h000200, 24'h00023F, 1'b0, 24'h0C0000};

    rst = 1'b1;
    read_enable = 1'b0;
    write_enable = 1'b0;
    address = '0;
    write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_read_data_nonzero", read_data != '0, 0);

    for (int v = 0; v < 6; v++) begin
      write_enable = (vecs[v].op != 2'd1);
      read_enable  = (vecs[v].op != 2'd0);
      address      = vecs[v].addr;
      for (int p = 0; p < 64; p++) write_data[p*24 +: 24] = vecs[v].seed + 24'(p);
      @(posedge clk);
      lat = 0; we_n = 0; re_n = 0; seq_err = 0; both_n = 0; busy_err = 0; mism = -1;
      first_a = '0; last_a = '0;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        if (c == 1) begin
          write_enable = 1'b0;
          read_enable  = 1'b0;
          address      = 24'h5A5A5A;
          write_data   = '1;
        end
        if (mem_we && mem_re) both_n++;
        if (!busy) busy_err++;
        if (mem_we) begin
          if (mem_addr !== vecs[v].addr + 24'(we_n) || mem_wdata !== vecs[v].seed + 24'(we_n))
            seq_err++;
          if (we_n == 0) first_a = mem_addr;
          last_a = mem_addr;
          we_n++;
        end
        if (mem_re) begin
          if (mem_addr !== vecs[v].addr + 24'(re_n)) seq_err++;
          if (re_n == 0) first_a = mem_addr;
          last_a = mem_addr;
          re_n++;
        end
        if (done) begin
          lat = c;
          mism = line_mismatches(read_data, vecs[v].rd_zero, vecs[v].rd_seed);
          break;
        end
      end
      chk($sformatf("v%0d_done_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_we_count", v), we_n, vecs[v].exp_we);
      chk($sformatf("v%0d_re_count", v), re_n, vecs[v].exp_re);
      chk($sformatf("v%0d_first_addr", v), first_a, vecs[v].exp_first);
      chk($sformatf("v%0d_last_addr", v), last_a, vecs[v].exp_last);
      chk($sformatf("v%0d_seq_errors", v), seq_err, 0);
      chk($sformatf("v%0d_we_re_overlap", v), both_n, 0);
      chk($sformatf("v%0d_busy_drop", v), busy_err, 0);
      chk($sformatf("v%0d_read_line_mismatches", v), mism, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", v), done, 0);
      chk($sformatf("v%0d_idle_after_done", v), busy, 0);
`ifdef SRAM_LINE_CTRL_PERF_CNT_EN
      if (v == 4) begin
        chk("perf_wr_count", wr_count, 3);
        chk("perf_rd_count", rd_count, 2);
      end
`endif
    end

    // Back-to-back: enable held through done starts a second write one IDLE cycle later.
    write_enable = 1'b1;
    address = 24'h000300;
    for (int p = 0; p < 64; p++) write_data[p*24 +: 24] = 24'h0D0000 + 24'(p);
    @(posedge clk);
    done_n = 0; lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 66) begin
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_we", mem_we, 0);
      end
      if (c == 67) begin
        chk("b2b_restart_we", mem_we, 1);
        chk("b2b_restart_addr", mem_addr, 24'h000300);
        write_enable = 1'b0;
      end
      if (done) begin
        done_n++;
        if (done_n == 1) chk("b2b_first_done", c, 65);
        if (done_n == 2) begin
          lat = c;
          break;
        end
      end
    end
    chk("b2b_second_done", lat, 131);
    @(negedge clk);

    // Reset during beat 20 of a read.
    read_enable = 1'b1;
    address = 24'h000100;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) read_enable = 1'b0;
    end
    chk("pre_rst_beat20_re", mem_re, 1);
    chk("pre_rst_beat20_addr", mem_addr, 24'h000114);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_re", mem_re, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_done", done, 0);
    @(posedge clk);
    #1;
    chk("midrst_edge_outputs", {busy, done, mem_we, mem_re, mem_addr, mem_wdata}, 0);
    chk("midrst_read_data_nonzero", read_data != '0, 0);
    @(negedge clk);
    rst = 1'b0;
    strobe_n = 0; done_n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_we || mem_re || busy) strobe_n++;
      if (done) done_n++;
    end
    chk("postrst_strobes", strobe_n, 0);
    chk("postrst_done", done_n, 0);
    chk("postrst_read_data_nonzero", read_data != '0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_line_ctrl.md
# sram_line_ctrl

Responder end of the shared SRAM request port driven by the alpha/fill request multiplexer. It accepts one 1536-bit line request (64 RGB888 pixels), serialises it into 64 single-pixel accesses on the 24-bit physical SRAM port, and reports completion. Reads are reassembled into a 1536-bit line for the requester.

## Interface
- LINE_W, 1536: request line width in bits.
- PIX_W, 24: pixel and physical SRAM data width.
- ADDR_W, 24: pixel address width.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_enable  input  1  line read request (level).
- write_enable  input  1  line write request (level).
- address  input  24  pixel address of pixel 0 of the line.
- write_data  input  1536  line data; pixel i is bits [24i+23:24i].
- read_data  output  1536  assembled read line.
- busy  output  1  a transaction is in progress.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  24  physical SRAM address.
- mem_wdata  output  24  physical write data.
- mem_we  output  1  physical write strobe.
- mem_re  output  1  physical read strobe.
- mem_rdata  input  24  physical read data, valid 1 cycle after mem_re.

## Operation
- FSM states: IDLE, WRITE, READ, READ_DRAIN, DONE.
- IDLE:
  - write_enable high → latch address and write_data, clear the beat counter, go to WRITE.
  - Otherwise read_enable high → latch address, go to READ.
  - Both high: write wins; the read is not performed.
- WRITE, per beat i = 0..63:
  - mem_we=1, mem_addr=base+i, mem_wdata=pixel i.
  - After beat 63, go to DONE.
- READ, per beat i:
  - mem_re=1, mem_addr=base+i.
  - The returning mem_rdata is stored into pixel slot i of read_data on the following cycle.
  - After beat 63, go to READ_DRAIN to capture the last pixel, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Address arithmetic: base+i is modulo 2^24, so 24'hFFFFFF wraps to 24'h000000.
- read_data:
  - Holds the last completed read line until the next read's first capture.
  - Unaffected by writes.
- Request inputs are ignored while busy. A changed address or write_data mid-transaction has no effect.
- A requester still asserting an enable in the cycle after done starts a new transaction. Requesters deassert on done.
- Reset values: all outputs 0, read_data all zero, state IDLE. Counters 0 when configured.
- Reset mid-transaction:
  - Immediately aborts the transaction; no further mem strobes occur.
  - No done pulse is issued.
  - The partial read line is cleared.

## Timing
- Request sampled in IDLE at edge T.
- Write:
  - mem_we high for cycles T+1..T+64.
  - done at T+65.
  - busy high for T+1..T+65.
- Read:
  - mem_re high for T+1..T+64.
  - Captures occur at T+2..T+65.
  - done at T+66, with read_data valid in the same cycle.
  - busy high for T+1..T+66.
- Earliest back-to-back: a next request can be accepted in the IDLE cycle following DONE.
- mem_we and mem_re are never high simultaneously.
- All outputs are registered.

## Configuration
- SRAM_LINE_CTRL_PERF_CNT_EN defined:
  - Adds outputs rd_count and wr_count, each 32 bits.
  - Each increments on its respective done pulse and wraps at 2^32.
  - Both reset to 0.
- Undefined: the counter ports and their logic do not exist. Behaviour is otherwise identical.

## Structure
- Shared package gpu_sram_pkg holds:
  - LINE_W, PIX_W, ADDR_W.
  - BEATS = 64.
  - The state enum type.
- One sub-module, sram_line_buffer:
  - 64×24 storage with a load-all port for write lines.
  - Indexed pixel read for mem_wdata.
  - Indexed pixel write for read capture.
  - Owned and sequenced by the FSM.

## Test plan
- Write, address 24'h000100, pixel i = 24'h0A0000+i → mem_we for 64 cycles, addresses 24'h000100..24'h00013F, matching wdata, done at T+65.
- Read-back of the same line with an SRAM model → read_data pixel i = 24'h0A0000+i, done at T+66, mem_re count = 64.
- Read at address 24'hFFFFF0 → mem_addr runs 24'hFFFFF0..24'hFFFFFF, then 24'h000000..24'h00002F.
- read_enable and write_enable asserted together → only a write occurs; read_data is unchanged.
- rst pulsed at beat 20 of a read → all outputs 0 on the next edge, no done, read_data all zero.
- Macro defined, 3 writes and 2 reads → wr_count = 3, rd_count = 2. Macro undefined → the design compiles without the counter ports.
